fsm_lock_serial_param: RTL and testbench
========================================

Name: fsm_lock_serial_param

Overview:
- Parametrised serial combination lock: code of CODE_LEN bits entered one bit per valid strobe, MSB first.
- Extends the fixed 3-bit lock with a configurable code length and a code that can be reprogrammed while unlocked.
- Adds a failed-attempt counter with a timed alarm lockout, and a timed unlock window.
- Sits between the keypad/bit-entry front end and the actuator/alarm drivers.

Parameters:
- CODE_LEN, 4: code length in bits (2..16).
- CODE_DEFAULT, 4'b1011: code loaded at reset (CODE_LEN bits).
- MAX_TRIES, 3: consecutive mismatches that trigger lockout (1..15).
- OPEN_CYCLES, 8: cycles Unlock stays high (>=1).
- LOCKOUT_CYCLES, 16: cycles Alarm stays high during lockout (>=1).

Ports:
- CLK  input  1  system clock, rising edge.
- R  input  1  reset, asynchronous, active-low (0 = reset).
- IN  input  1  code bit, sampled when IN_VALID=1.
- IN_VALID  input  1  bit strobe, one bit accepted per cycle.
- CLEAR  input  1  abort partial entry or programming.
- PROG  input  1  program mode qualifier; honoured only in UNLOCKED.
- Unlock  output  1  lock released (registered).
- Alarm  output  1  lockout alarm (registered).
- Err  output  1  one-cycle pulse per mismatching attempt.
- Prog_done  output  1  one-cycle pulse when a new code has been stored.

Behaviour:
- Reset (R=0, async):
  - state=ENTRY; bit count=0; shift register=0; fail count=0.
  - code_reg=CODE_DEFAULT.
  - Unlock=0, Alarm=0, Err=0, Prog_done=0.
- All outputs are registered and change only on CLK rising edge, except the async reset clear.
- ENTRY:
  - Each IN_VALID shifts IN in at the LSB and increments the bit count.
  - On the CODE_LEN-th accepted bit, compare the full word with code_reg.
  - Match: next cycle -> UNLOCKED; fail count=0; Unlock=1.
  - Mismatch: Err pulses the next cycle and fail count increments.
  - If the new fail count equals MAX_TRIES: -> LOCKOUT with Alarm=1 from the next cycle.
  - Otherwise stay in ENTRY.
  - Bit count returns to 0 after every complete attempt.
- CLEAR in ENTRY: bit count=0 and the shift register is discarded; fail count is unchanged.
  - CLEAR and IN_VALID in the same cycle: CLEAR wins and the bit is dropped.
- UNLOCKED:
  - Unlock=1 for exactly OPEN_CYCLES cycles, then -> ENTRY with Unlock=0.
  - IN_VALID with PROG=0 is ignored.
  - IN_VALID with PROG=1 shifts into the program register.
  - On the CODE_LEN-th program bit: code_reg is updated, Prog_done pulses the next cycle, and the open timer reloads to OPEN_CYCLES.
  - PROG falling mid-sequence or CLEAR: partial program bits are discarded and code_reg is unchanged.
  - Open timer expiring mid-program: partial bits are discarded and the state goes -> ENTRY.
  - Expiry in the same cycle as the final program bit: the code is stored, Prog_done pulses, and the timer reloads (store wins).
- LOCKOUT:
  - Alarm=1 for exactly LOCKOUT_CYCLES cycles; IN_VALID, CLEAR and PROG are ignored.
  - On expiry -> ENTRY, with Alarm=0, fail count=0, bit count=0.
- Invariants:
  - Unlock and Alarm are never both 1.
  - Err and Prog_done are single-cycle pulses.
- Widths:
  - Timers are sized by $clog2 of the max of OPEN_CYCLES and LOCKOUT_CYCLES, plus 1.
  - Fail count is sized by $clog2(MAX_TRIES+1).
- Reset mid-operation: immediate return to reset values.
  - code_reg reverts to CODE_DEFAULT; reprogrammed codes are not retained.

Test Plan:
(Defaults throughout.)
1. Correct code: release reset; enter 1,0,1,1 on 4 consecutive cycles -> Unlock=1 the cycle after bit 4, held 8 cycles, then 0; Err never pulses.
2. Lockout: enter 0000 three times -> Err pulses after each attempt; Alarm=1 after the 3rd attempt for 16 cycles. Entering 1011 during the alarm gives no Unlock. After the alarm ends, 1011 -> Unlock=1.
3. Fail-count reset: two wrong attempts, then 1011 -> Unlock. After relock, two more wrong attempts -> no Alarm, because the count was cleared by the success.
4. CLEAR: enter 1,0, then CLEAR together with IN_VALID/IN=1, then 1,0,1,1 -> Unlock; the dropped bit has no effect.
5. Reprogram: unlock; PROG=1 and enter 0110 -> Prog_done pulse with Unlock held 8 cycles from the pulse. After relock, 1011 -> Err; 0110 -> Unlock.
6. Async reset: assert R=0 mid-way through case 5 programming and mid-lockout -> all outputs 0 immediately; afterwards 1011 unlocks.

Source files
------------

// File: rtl/fsm_lock_serial_param.sv
// Serial combination lock with configurable code length, reprogrammable code,
// failed-attempt lockout with a timed alarm, and a timed unlock window.
// Code bits arrive MSB first, one per IN_VALID strobe.
module fsm_lock_serial_param #(
    parameter int unsigned          CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0]  CODE_DEFAULT   = 4'b1011,
    parameter int unsigned          MAX_TRIES      = 3,
    parameter int unsigned          OPEN_CYCLES    = 8,
    parameter int unsigned          LOCKOUT_CYCLES = 16
) (
    input  logic CLK,
    input  logic R,
    input  logic IN,
    input  logic IN_VALID,
    input  logic CLEAR,
    input  logic PROG,
    output logic Unlock,
    output logic Alarm,
    output logic Err,
    output logic Prog_done
);

    localparam int unsigned TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int unsigned FAIL_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
    // Only the earlier CODE_LEN-1 bits need storing; the final bit is taken live.
    logic [CODE_LEN-2:0]   shift_r, shift_nxt_s;
    logic [FAIL_W-1:0]     fail_r, fail_nxt_s;
    logic [CODE_LEN-1:0]   code_r, code_nxt_s;
    logic [TMR_W-1:0]      tmr_r, tmr_nxt_s;
    logic                  err_ev_s, store_ev_s;
    logic                  unlock_nxt_s, alarm_nxt_s, err_nxt_s, prog_done_nxt_s;

    logic [CODE_LEN-1:0]   word_s;
    logic                  last_bit_s;
    logic                  prog_ok_s;
    logic                  tmr_last_s;

    assign word_s     = {shift_r, IN};
    assign last_bit_s = (cnt_r == CNT_W'(CODE_LEN - 1));
    assign prog_ok_s  = PROG & ~CLEAR;
    assign tmr_last_s = (tmr_r == TMR_W'(1));

    // State and datapath registers, plus registered outputs.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_r   <= ST_ENTRY;
            cnt_r     <= {CNT_W{1'b0}};
            shift_r   <= {(CODE_LEN-1){1'b0}};
            fail_r    <= {FAIL_W{1'b0}};
            code_r    <= CODE_DEFAULT;
            tmr_r     <= {TMR_W{1'b0}};
            Unlock    <= 1'b0;
            Alarm     <= 1'b0;
            Err       <= 1'b0;
            Prog_done <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            fail_r    <= fail_nxt_s;
            code_r    <= code_nxt_s;
            tmr_r     <= tmr_nxt_s;
            Unlock    <= unlock_nxt_s;
            Alarm     <= alarm_nxt_s;
            Err       <= err_nxt_s;
            Prog_done <= prog_done_nxt_s;
        end
    end

    // Next-state and datapath update: attempt checking, programming and timers.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        shift_nxt_s = shift_r;
        fail_nxt_s  = fail_r;
        code_nxt_s  = code_r;
        tmr_nxt_s   = tmr_r;
        err_ev_s    = 1'b0;
        store_ev_s  = 1'b0;
        case (state_r)
            ST_ENTRY: begin
                if (CLEAR) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    shift_nxt_s = {(CODE_LEN-1){1'b0}};
                end else if (IN_VALID && last_bit_s) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    shift_nxt_s = {(CODE_LEN-1){1'b0}};
                    if (word_s == code_r) begin
                        state_nxt_s = ST_UNLOCKED;
                        fail_nxt_s  = {FAIL_W{1'b0}};
                        tmr_nxt_s   = TMR_W'(OPEN_CYCLES);
                    end else begin
                        err_ev_s   = 1'b1;
                        fail_nxt_s = fail_r + FAIL_W'(1);
                        if (fail_r == FAIL_W'(MAX_TRIES - 1)) begin
                            state_nxt_s = ST_LOCKOUT;
                            tmr_nxt_s   = TMR_W'(LOCKOUT_CYCLES);
                        end else begin
                            state_nxt_s = ST_ENTRY;
                        end
                    end
                end else if (IN_VALID) begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                    shift_nxt_s = word_s[CODE_LEN-2:0];
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_UNLOCKED: begin
                // A completed program word beats a simultaneous timer expiry.
                if (prog_ok_s && IN_VALID && last_bit_s) begin
                    code_nxt_s  = word_s;
                    store_ev_s  = 1'b1;
                    tmr_nxt_s   = TMR_W'(OPEN_CYCLES);
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    shift_nxt_s = {(CODE_LEN-1){1'b0}};
                end else if (tmr_last_s) begin
                    state_nxt_s = ST_ENTRY;
                    tmr_nxt_s   = {TMR_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    shift_nxt_s = {(CODE_LEN-1){1'b0}};
                end else begin
                    tmr_nxt_s = tmr_r - TMR_W'(1);
                    if (!prog_ok_s) begin
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        shift_nxt_s = {(CODE_LEN-1){1'b0}};
                    end else if (IN_VALID) begin
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                        shift_nxt_s = word_s[CODE_LEN-2:0];
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (tmr_last_s) begin
                    state_nxt_s = ST_ENTRY;
                    tmr_nxt_s   = {TMR_W{1'b0}};
                    fail_nxt_s  = {FAIL_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    shift_nxt_s = {(CODE_LEN-1){1'b0}};
                end else begin
                    tmr_nxt_s = tmr_r - TMR_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_ENTRY;
                cnt_nxt_s   = {CNT_W{1'b0}};
                shift_nxt_s = {(CODE_LEN-1){1'b0}};
                fail_nxt_s  = {FAIL_W{1'b0}};
                tmr_nxt_s   = {TMR_W{1'b0}};
            end
        endcase
    end

    // Output decode from the upcoming state and this cycle's events.
    always_comb begin
        unlock_nxt_s    = (state_nxt_s == ST_UNLOCKED);
        alarm_nxt_s     = (state_nxt_s == ST_LOCKOUT);
        err_nxt_s       = err_ev_s;
        prog_done_nxt_s = store_ev_s;
    end

endmodule

// File: tb/tb_fsm_lock_serial_param.sv
// Bench for fsm_lock_serial_param: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_fsm_lock_serial_param;

    localparam int CL   = 4;
    localparam int OPEN = 8;
    localparam int LOCK = 16;
    localparam int MAXT = 3;

    logic CLK = 1'b0;
    logic R = 1'b0;
    logic IN = 1'b0;
    logic IN_VALID = 1'b0;
    logic CLEAR = 1'b0;
    logic PROG = 1'b0;
    logic Unlock, Alarm, Err, Prog_done;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: remaining-cycle counters and collected bits.
    int         m_open  = 0;
    int         m_alarm = 0;
    int         m_fail  = 0;
    int         e_cnt   = 0;
    int         p_cnt   = 0;
    logic [3:0] e_word  = 4'b0000;
    logic [3:0] p_word  = 4'b0000;
    logic [3:0] m_code  = 4'b1011;
    logic       exp_err = 1'b0;
    logic       exp_pd  = 1'b0;

    fsm_lock_serial_param dut (
        .CLK      (CLK),
        .R        (R),
        .IN       (IN),
        .IN_VALID (IN_VALID),
        .CLEAR    (CLEAR),
        .PROG     (PROG),
        .Unlock   (Unlock),
        .Alarm    (Alarm),
        .Err      (Err),
        .Prog_done(Prog_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advanced on each clock edge or reset.
    initial begin
        forever begin
            @(posedge CLK or negedge R);
            if (!R) begin
                m_open = 0; m_alarm = 0; m_fail = 0; e_cnt = 0; p_cnt = 0;
                e_word = 4'b0000; p_word = 4'b0000; m_code = 4'b1011;
                exp_err = 1'b0; exp_pd = 1'b0;
            end else begin
                exp_err = 1'b0;
                exp_pd  = 1'b0;
                if (m_alarm > 0) begin
                    m_alarm--;
                    if (m_alarm == 0) begin
                        m_fail = 0;
                        e_cnt  = 0;
                    end
                end else if (m_open > 0) begin
                    if (PROG && !CLEAR && IN_VALID && p_cnt == CL - 1) begin
                        m_code = {p_word[2:0], IN};
                        p_cnt  = 0;
                        exp_pd = 1'b1;
                        m_open = OPEN;
                    end else begin
                        m_open--;
                        if (m_open == 0 || !PROG || CLEAR) begin
                            p_cnt = 0;
                        end else if (IN_VALID) begin
                            p_word = {p_word[2:0], IN};
                            p_cnt++;
                        end
                    end
                end else begin
                    if (CLEAR) begin
                        e_cnt = 0;
                    end else if (IN_VALID) begin
                        e_word = {e_word[2:0], IN};
                        e_cnt++;
                        if (e_cnt == CL) begin
                            e_cnt = 0;
                            if (e_word == m_code) begin
                                m_open = OPEN;
                                m_fail = 0;
                                p_cnt  = 0;
                            end else begin
                                exp_err = 1'b1;
                                m_fail++;
                                if (m_fail == MAXT) m_alarm = LOCK;
                            end
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge CLK);
            chk("unlock", Unlock, (m_open > 0) ? 1'b1 : 1'b0);
            chk("alarm", Alarm, (m_alarm > 0) ? 1'b1 : 1'b0);
            chk("err", Err, exp_err);
            chk("prog_done", Prog_done, exp_pd);
            chk("unlock_alarm_excl", Unlock & Alarm, 1'b0);
        end
    end

    task automatic cyc(input logic v, input logic b, input logic c, input logic p);
        IN_VALID = v; IN = b; CLEAR = c; PROG = p;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0; IN = 1'b0; CLEAR = 1'b0; PROG = 1'b0;
    endtask

    task automatic send_code(input logic [3:0] code, input logic p);
        for (int i = 3; i >= 0; i--) cyc(1'b1, code[i], 1'b0, p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #2 R = 1'b0;
        #1;
        chk("rst_unlock", Unlock, 1'b0);
        chk("rst_alarm", Alarm, 1'b0);
        chk("rst_err", Err, 1'b0);
        chk("rst_pd", Prog_done, 1'b0);
        #3 R = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [3:0] rc;
        int act;
        #1;
        chk("por_unlock", Unlock, 1'b0);
        chk("por_alarm", Alarm, 1'b0);
        #11 R = 1'b1;
        @(posedge CLK);
        #1;

        // Correct code opens for exactly OPEN cycles
        send_code(4'b1011, 1'b0);
        chk("t1_unlock", Unlock, 1'b1);
        chk("t1_err", Err, 1'b0);
        idle(7);
        chk("t1_hold", Unlock, 1'b1);
        idle(1);
        chk("t1_relock", Unlock, 1'b0);

        // Three failures -> lockout; code ignored while alarmed
        for (int k = 0; k < 3; k++) begin
            send_code(4'b0000, 1'b0);
            chk("t2_err", Err, 1'b1);
        end
        chk("t2_alarm", Alarm, 1'b1);
        send_code(4'b1011, 1'b0);
        chk("t2_no_unlock", Unlock, 1'b0);
        idle(11);
        chk("t2_alarm_hold", Alarm, 1'b1);
        idle(1);
        chk("t2_alarm_end", Alarm, 1'b0);
        send_code(4'b1011, 1'b0);
        chk("t2_unlock", Unlock, 1'b1);
        idle(8);

        // Success clears the fail count
        send_code(4'b0000, 1'b0);
        send_code(4'b0001, 1'b0);
        send_code(4'b1011, 1'b0);
        chk("t3_unlock", Unlock, 1'b1);
        idle(8);
        send_code(4'b0000, 1'b0);
        send_code(4'b0000, 1'b0);
        chk("t3_err", Err, 1'b1);
        chk("t3_no_alarm", Alarm, 1'b0);

        // CLEAR beats a simultaneous bit
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        send_code(4'b1011, 1'b0);
        chk("t4_unlock", Unlock, 1'b1);
        idle(8);

        // Reprogram to 0110
        send_code(4'b1011, 1'b0);
        send_code(4'b0110, 1'b1);
        chk("t5_pd", Prog_done, 1'b1);
        chk("t5_unlock", Unlock, 1'b1);
        idle(1);
        chk("t5_pd_pulse", Prog_done, 1'b0);
        idle(6);
        chk("t5_hold", Unlock, 1'b1);
        idle(1);
        chk("t5_relock", Unlock, 1'b0);
        send_code(4'b1011, 1'b0);
        chk("t5_old_err", Err, 1'b1);
        send_code(4'b0110, 1'b0);
        chk("t5_new_unlock", Unlock, 1'b1);
        idle(8);

        // Final program bit on the expiry cycle: store wins
        send_code(4'b0110, 1'b0);
        idle(4);
        send_code(4'b1011, 1'b1);
        chk("sw_pd", Prog_done, 1'b1);
        chk("sw_unlock", Unlock, 1'b1);
        idle(8);

        // Expiry mid-program discards the partial word
        send_code(4'b1011, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("ex_relock", Unlock, 1'b0);
        chk("ex_no_pd", Prog_done, 1'b0);
        send_code(4'b1011, 1'b0);
        chk("ex_code_kept", Unlock, 1'b1);
        idle(8);

        // Async reset mid-programming and mid-lockout
        send_code(4'b1011, 1'b0);
        send_code(4'b0110, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        do_reset();
        send_code(4'b1011, 1'b0);
        chk("t6_unlock", Unlock, 1'b1);
        idle(8);
        for (int k = 0; k < 3; k++) send_code(4'b0000, 1'b0);
        idle(5);
        chk("t6_alarm", Alarm, 1'b1);
        do_reset();
        send_code(4'b1011, 1'b0);
        chk("t6_unlock2", Unlock, 1'b1);
        idle(8);

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            act = $urandom_range(0, 9);
            if (act <= 2) begin
                send_code(m_code, 1'($urandom_range(0, 1)));
            end else if (act <= 5) begin
                for (int j = 0; j < 4; j++)
                    cyc(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
            end else if (act <= 7) begin
                rc = 4'($urandom_range(0, 15));
                send_code(rc, 1'b1);
            end else if (act == 8) begin
                idle($urandom_range(1, 10));
            end else if ($urandom_range(0, 9) == 0) begin
                do_reset();
            end else begin
                cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
            end
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
